// File: rtl/multicycle_control.sv
// Multicycle control unit for the 8-bit RISC-V-subset datapath.
// Moore FSM: mux selects and ALU control decode from the current state.
// PCWrite in BEQ also follows Zero, ImmSrc follows OP, and Illegal follows OP in DECODE.
// The run/pause enable freezes the FSM and masks every architectural write strobe.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] OP,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ULAControl,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned OP_W    = 7;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

  localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_BEQ      = 4'd9
  } state_t;

  state_t           r_state;
  logic             w_is_lw;
  logic             w_is_sw;
  logic             w_is_rtype;
  logic             w_is_itype;
  logic             w_is_beq;
  logic             w_legal;
  logic [ALU_W-1:0] w_alu_dec;
  logic             w_pc_write;
  logic             w_ir_write;
  logic             w_mem_write;
  logic             w_reg_write;

  // Opcode classification shared by the sequencer and the decoders.
  always_comb begin
    w_is_lw    = (OP == OP_LW);
    w_is_sw    = (OP == OP_SW);
    w_is_rtype = (OP == OP_RTYPE);
    w_is_itype = (OP == OP_ITYPE);
    w_is_beq   = (OP == OP_BEQ);
    w_legal    = w_is_lw | w_is_sw | w_is_rtype | w_is_itype | w_is_beq;
  end

  // State sequencer: reset wins over enable; a low enable holds the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else if (en) begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          if (w_is_lw || w_is_sw) r_state <= S_MEMADR;
          else if (w_is_rtype)    r_state <= S_EXECUTER;
          else if (w_is_itype)    r_state <= S_EXECUTEI;
          else if (w_is_beq)      r_state <= S_BEQ;
          else                    r_state <= S_FETCH;
        end
        S_MEMADR:   r_state <= w_is_sw ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  r_state <= S_MEMWB;
        S_EXECUTER: r_state <= S_ALUWB;
        S_EXECUTEI: r_state <= S_ALUWB;
        // MEMWB, MEMWRITE, ALUWB, BEQ and unused codes all return to FETCH.
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // ALU operation for the execute states; addi never subtracts.
  always_comb begin
    w_alu_dec = ALU_ADD;
    case (Funct3)
      3'b000:  w_alu_dec = (w_is_rtype && Funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_dec = ALU_SLT;
      3'b110:  w_alu_dec = ALU_OR;
      3'b111:  w_alu_dec = ALU_AND;
      default: w_alu_dec = ALU_ADD;
    endcase
  end

  // Immediate format depends only on the opcode.
  always_comb begin
    ImmSrc = 2'b00;
    if (w_is_sw)       ImmSrc = 2'b01;
    else if (w_is_beq) ImmSrc = 2'b10;
  end

  // Per-state selects and unmasked write strobes.
  always_comb begin
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ULAControl  = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ULAControl = w_alu_dec;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ULAControl = w_alu_dec;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ULAControl = ALU_SUB;
        w_pc_write = Zero;
      end
      default: ;
    endcase
  end

  // Architectural writes only happen while stepping.
  always_comb begin
    PCWrite  = w_pc_write  & en;
    IRWrite  = w_ir_write  & en;
    MemWrite = w_mem_write & en;
    RegWrite = w_reg_write & en;
    Illegal  = en & (r_state == S_DECODE) & ~w_legal;
    State    = STATE_W'(r_state);
  end

endmodule
